// File: rtl/dm_host_bridge.sv
// Host-side data-memory bridge: preload/readback port, core reset/launch control, run-cycle count.
// Optional run timeout enabled by defining DM_HOST_TIMEOUT_EN.
module dm_host_bridge #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_we,
  input  logic          host_re,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          host_start,
  output logic          host_busy,
  output logic          host_done,
  output logic [CW-1:0] host_cycles,
  output logic          host_timeout,
  output logic          core_reset,
  input  logic          core_done,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [CW-1:0] CyclesMax = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          timeout_q, timeout_d;
  logic          core_reset_q, core_reset_d;
  logic          host_own;

  assign host_own = (state_q == S_IDLE) || (state_q == S_FINISH);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    if (host_own && host_re) begin
      rdata_d  = mem_q[host_addr];
      rvalid_d = 1'b1;
    end
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (host_start) begin
          state_d   = S_LAUNCH;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        cycles_d = (cycles_q == CyclesMax) ? cycles_q : cycles_q + CW'(1);
        if (core_done) begin
          state_d = S_FINISH;
        end
`ifdef DM_HOST_TIMEOUT_EN
        else if (cycles_d == CW'(TIMEOUT)) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d       = (state_d == S_LAUNCH) || (state_d == S_RUN);
    done_d       = (state_d == S_FINISH);
    core_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Array is deliberately not reset; write port belongs to the host outside RUN, to the core in RUN
  always_ff @(posedge clk) begin
    if (host_own && host_we) begin
      mem_q[host_addr] <= host_wdata;
    end else if ((state_q == S_RUN) && core_we) begin
      mem_q[core_addr] <= core_wdata;
    end
  end

  assign core_rdata   = mem_q[core_addr];
  assign host_rdata   = rdata_q;
  assign host_rvalid  = rvalid_q;
  assign host_busy    = busy_q;
  assign host_done    = done_q;
  assign host_cycles  = cycles_q;
  assign host_timeout = timeout_q;
  assign core_reset   = core_reset_q;

endmodule

// File: tb/tb_dm_host_bridge.sv
// Directed self-checking bench for dm_host_bridge (CW narrowed to 4 to reach saturation quickly).
module tb_dm_host_bridge;

  localparam int unsigned AW      = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_we, host_re, host_start;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid, host_busy, host_done, host_timeout;
  logic [CW-1:0] host_cycles;
  logic          core_reset, core_done, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;

  int checks   = 0;
  int failures = 0;
  int low_cnt;

  always #5 clk = ~clk;

  dm_host_bridge #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .host_we(host_we), .host_re(host_re), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_start(host_start),
    .host_busy(host_busy), .host_done(host_done), .host_cycles(host_cycles),
    .host_timeout(host_timeout), .core_reset(core_reset), .core_done(core_done),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic hread(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    host_addr = a;
    host_re   = 1'b1;
    tick();
    host_re   = 1'b0;
    chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
    chk(tag, 32'(host_rdata), 32'(exp));
    tick();
    chk({tag, "_rvalid_pulse"}, 32'(host_rvalid), 32'd0);
  endtask

  // Start from IDLE/FINISH; leaves the bench in the first RUN cycle
  task automatic launch(input string tag);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk({tag, "_launch_busy"}, 32'(host_busy), 32'd1);
    chk({tag, "_launch_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_launch_cycles"}, 32'(host_cycles), 32'd0);
    chk({tag, "_launch_timeout"}, 32'(host_timeout), 32'd0);
    tick();
    chk({tag, "_run_core_reset"}, 32'(core_reset), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    host_we = 1'b0; host_re = 1'b0; host_start = 1'b0;
    host_addr = '0; host_wdata = '0;
    core_done = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;

    // Reset values
    #1;
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_busy", 32'(host_busy), 32'd0);
    chk("rst_done", 32'(host_done), 32'd0);
    chk("rst_cycles", 32'(host_cycles), 32'd0);
    chk("rst_timeout", 32'(host_timeout), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // core_done in IDLE is ignored
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("idle_done_ignored", 32'(host_done), 32'd0);
    chk("idle_busy", 32'(host_busy), 32'd0);

    // T2 preload, launch, core reads/writes, done, readback
    hwrite(8'd0, 8'h01);
    hwrite(8'd1, 8'h02);
    launch("t2");
    core_addr = 8'd0; #1;
    chk("t2_core_rd0", 32'(core_rdata), 32'h01);
    core_addr = 8'd1; #1;
    chk("t2_core_rd1", 32'(core_rdata), 32'h02);
    core_we = 1'b1; core_addr = 8'd2; core_wdata = 8'h03;
    tick();
    core_we = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("t2_done", 32'(host_done), 32'd1);
    chk("t2_busy", 32'(host_busy), 32'd0);
    chk("t2_core_reset", 32'(core_reset), 32'd1);
    chk("t2_cycles", 32'(host_cycles), 32'd2);
    hread("t2_rd2", 8'd2, 8'h03);

    // core_we outside RUN is ignored
    core_we = 1'b1; core_addr = 8'd2; core_wdata = 8'h55;
    tick();
    core_we = 1'b0;
    hread("finish_core_we_ignored", 8'd2, 8'h03);

    // Same-cycle write and read of one address returns old data
    hwrite(8'd5, 8'h5A);
    host_addr = 8'd5; host_wdata = 8'hAA; host_we = 1'b1; host_re = 1'b1;
    tick();
    host_we = 1'b0; host_re = 1'b0;
    chk("wr_rd_old_valid", 32'(host_rvalid), 32'd1);
    chk("wr_rd_old_data", 32'(host_rdata), 32'h5A);
    hread("wr_rd_new", 8'd5, 8'hAA);

    // T3 RUN lockout: host strobes and host_start ignored
    launch("t3");
    host_addr = 8'd2; host_wdata = 8'hFF; host_we = 1'b1; host_re = 1'b1;
    tick();
    host_we = 1'b0; host_re = 1'b0;
    chk("t3_no_rvalid", 32'(host_rvalid), 32'd0);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("t3_start_ignored_busy", 32'(host_busy), 32'd1);
    chk("t3_start_ignored_core_reset", 32'(core_reset), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("t3_done", 32'(host_done), 32'd1);
    chk("t3_cycles", 32'(host_cycles), 32'd3);
    hread("t3_rd2", 8'd2, 8'h03);

    // T4 done after 10 RUN cycles; core_reset low exactly 10 cycles
    launch("t4");
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_reset == 1'b0) low_cnt++;
      core_done = (i == 9);
      tick();
    end
    core_done = 1'b0;
    chk("t4_low_cycles", 32'(low_cnt), 32'd10);
    chk("t4_cycles", 32'(host_cycles), 32'd10);
    chk("t4_done", 32'(host_done), 32'd1);

    // Access alongside host_start completes, then LAUNCH; T5 mid-run reset
    host_addr = 8'd0; host_re = 1'b1; host_start = 1'b1;
    tick();
    host_re = 1'b0; host_start = 1'b0;
    chk("start_rd_valid", 32'(host_rvalid), 32'd1);
    chk("start_rd_data", 32'(host_rdata), 32'h01);
    chk("start_rd_busy", 32'(host_busy), 32'd1);
    chk("start_rd_cycles", 32'(host_cycles), 32'd0);
    tick();
    core_we = 1'b1; core_addr = 8'd10; core_wdata = 8'h77;
    tick();
    core_we = 1'b0;
    tick(); tick(); tick();
    chk("t5_pre_cycles", 32'(host_cycles), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", 32'(host_busy), 32'd0);
    chk("t5_core_reset", 32'(core_reset), 32'd1);
    chk("t5_cycles", 32'(host_cycles), 32'd0);
    chk("t5_done", 32'(host_done), 32'd0);
    #1 reset = 1'b0;
    tick();
    hread("t5_rd10", 8'd10, 8'h77);
    hread("t5_rd0", 8'd0, 8'h01);

`ifdef DM_HOST_TIMEOUT_EN
    // T6 timeout after 8 RUN cycles, then done on the 8th cycle wins
    launch("t6a");
    for (int i = 0; i < 7; i++) tick();
    chk("t6a_still_busy", 32'(host_busy), 32'd1);
    tick();
    chk("t6a_done", 32'(host_done), 32'd1);
    chk("t6a_timeout", 32'(host_timeout), 32'd1);
    chk("t6a_cycles", 32'(host_cycles), 32'd8);
    launch("t6b");
    for (int i = 0; i < 7; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("t6b_done", 32'(host_done), 32'd1);
    chk("t6b_timeout", 32'(host_timeout), 32'd0);
    chk("t6b_cycles", 32'(host_cycles), 32'd8);
`else
    // Long run: counter saturates, no timeout
    launch("sat");
    for (int i = 0; i < 20; i++) tick();
    chk("sat_busy", 32'(host_busy), 32'd1);
    chk("sat_cycles", 32'(host_cycles), 32'd15);
    chk("sat_timeout", 32'(host_timeout), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("sat_done", 32'(host_done), 32'd1);
    chk("sat_final_cycles", 32'(host_cycles), 32'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
